mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one 12-bit-address / 16-bit-data memory port between two requesters:
//  port 0 (mcu instruction/data side) and port 1 (DMA/IO side).
//  Per-port req/ack handshake; round-robin on ties; latched request fields.
//  Bounded wait on mem_ready; an access that times out completes with an error.
//  Sits between the processor core and the memory model, replacing direct men/mw/maddr drive.
// PARAMETERS
//  AW       12  address width
//  DW       16  data width
//  TIMEOUT  15  max ACCESS cycles without mem_ready before abort (>=1)
// PORTS
//  clock      in   1   system clock, all state changes on posedge
//  reset      in   1   synchronous, active-high
//  m0_req     in   1   port 0 request; held high until m0_ack
//  m0_we      in   1   port 0 write (1) / read (0)
//  m0_addr    in   AW  port 0 address
//  m0_wdata   in   DW  port 0 write data
//  m0_rdata   out  DW  port 0 read data, valid with m0_ack on reads
//  m0_ack     out  1   port 0 completion pulse, 1 cycle
//  m0_err     out  1   port 0 timeout flag, high only together with m0_ack
//  m1_*       -    -   identical set for port 1
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, sampled when mem_ready=1
//  mem_ready  in   1   memory completion, sampled only in ACCESS
//  grant      out  2   one-hot owner (bit0=port0); 00 in IDLE
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: reset is synchronous, active-high; clock is clock.
//   Reset drives state=IDLE, last=1 (port 0 wins first tie), wait counter=0.
//   All outputs 0, including rdata.
//   Mid-operation reset aborts the transfer: no ack, mem_en=0 next cycle.
//  FSM (all outputs registered):
//   IDLE:
//    - no req: stay.
//    - exactly one req: grant that port.
//    - both req: grant port != last.
//    - on grant: latch we/addr/wdata, set last=granted port, go ACCESS.
//   ACCESS:
//    - mem_en=1, mem_we/mem_addr/mem_wdata = latched values; wait counter increments.
//    - mem_ready=1 at an edge: go DONE; on a read, load owner rdata from mem_rdata.
//    - counter reaches TIMEOUT without mem_ready: go DONE with err set; rdata unchanged.
//   DONE:
//    - mem_en=0, mem_we=0; owner ack=1 (err=1 on timeout); counter cleared.
//    - go IDLE unconditionally.
//  Latency:
//   - req seen high at edge N -> mem_en high from cycle N+1.
//   - mem_ready in cycle K -> ack in cycle K+1.
//   - Minimum 3 cycles per transfer (IDLE, ACCESS, DONE); one idle bus cycle between transfers.
//  Handshake:
//   - Requester drops req by the edge ending its ack cycle.
//   - req still high in the following IDLE starts a new transfer.
//   - Changes to the owner's we/addr/wdata after the grant are ignored.
//   - The non-owner's req waits; it is never dropped.
//  mem_ready in IDLE/DONE: ignored. ack/err are never high outside DONE.
//  rdata holds its value until the next successful read on that port.
//  Writes never modify rdata.
//  grant is non-zero only in ACCESS/DONE; mem_* outputs are 0 in IDLE and DONE.
// TESTING
//  1 Reset: reset=1 for 2 cycles with m0_req=1
//    -> all outputs 0, grant=00, no mem_en.
//  2 m0 read 0x123; mem_ready 2 cycles after mem_en with mem_rdata=0xBEEF
//    -> mem_addr=0x123, mem_we=0, m0_rdata=0xBEEF, 1-cycle m0_ack, m0_err=0.
//  3 m0_req and m1_req held high from reset
//    -> grant sequence 01,10,01,10; one idle cycle between mem_en bursts.
//  4 m1 write 0x0A5/0x1234; m1_wdata changed to 0xFFFF after grant
//    -> mem_wdata=0x1234, mem_we=1, m1_rdata unchanged, m1_ack pulse.
//  5 m0 read with mem_ready never asserted
//    -> mem_en high exactly 15 cycles, then m0_ack=m0_err=1 for one cycle.
//  6 reset asserted during ACCESS
//    -> next cycle IDLE, mem_en=0, no ack; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: round-robin grant on ties, latched request fields,
// bounded wait on mem_ready with an error completion when the memory never answers.
module mem_bus_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter only has to reach TIMEOUT-1: the final ACCESS cycle is the one that aborts.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_grant;
    logic          r_busy;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          r_m0_ack;
    logic          r_m0_err;
    logic          r_m1_ack;
    logic          r_m1_err;

    logic          w_any_req;
    logic          w_pick;
    logic          w_timeout;
    logic          w_finish;

    assign w_any_req = m0_req | m1_req;
    // On a tie the port that did not win last time gets the bus.
    assign w_pick    = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_finish  = mem_ready | w_timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_grant     <= 2'b00;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m1_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ACCESS;
                        r_owner     <= w_pick;
                        r_last      <= w_pick;
                        r_grant     <= w_pick ? 2'b10 : 2'b01;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_pick ? m1_we    : m0_we;
                        r_mem_addr  <= w_pick ? m1_addr  : m0_addr;
                        r_mem_wdata <= w_pick ? m1_wdata : m0_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (w_finish) begin
                        r_state     <= ST_DONE;
                        r_cnt       <= '0;
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (r_owner) begin
                            r_m1_ack <= 1'b1;
                            r_m1_err <= ~mem_ready;
                        end else begin
                            r_m0_ack <= 1'b1;
                            r_m0_err <= ~mem_ready;
                        end
                        // A successful read is the only thing that updates rdata.
                        if (mem_ready && !r_mem_we) begin
                            if (r_owner) r_m1_rdata <= mem_rdata;
                            else         r_m0_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_grant  <= 2'b00;
                    r_busy   <= 1'b0;
                    r_m0_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m1_err <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_rdata  = r_m0_rdata;
    assign m0_ack    = r_m0_ack;
    assign m0_err    = r_m0_err;
    assign m1_rdata  = r_m1_rdata;
    assign m1_ack    = r_m1_ack;
    assign m1_err    = r_m1_err;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change and outputs are checked on the falling edge.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [11:0] m0_addr, m1_addr, mem_addr;
    logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_en, mem_we, mem_ready, busy;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;
    int en_cycles;

    mem_bus_arbiter #(.AW(12), .DW(16), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        // Reset held for two edges with a pending request
        step(); step();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_grant",  32'(grant),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_outs",   32'({m0_ack, m0_err, m1_ack, m1_err, mem_we}), 32'd0);
        chk("rst_rdata",  32'({m0_rdata, m1_rdata}), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);
        m0_req = 1'b0; reset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // m0 read of 0x123, ready two cycles after mem_en rises
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h123;
        step();
        chk("rd_mem_en", 32'(mem_en),   32'd1);
        chk("rd_addr",   32'(mem_addr), 32'h123);
        chk("rd_we",     32'(mem_we),   32'd0);
        chk("rd_grant",  32'(grant),    32'b01);
        chk("rd_busy",   32'(busy),     32'd1);
        step();
        chk("rd_noack",  32'(m0_ack),   32'd0);
        step();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        step();
        chk("rd_ack",    32'(m0_ack),   32'd1);
        chk("rd_err",    32'(m0_err),   32'd0);
        chk("rd_rdata",  32'(m0_rdata), 32'hBEEF);
        chk("rd_done_en",32'(mem_en),   32'd0);
        chk("rd_m1_ack", 32'(m1_ack),   32'd0);
        m0_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("rd_ack_pulse", 32'(m0_ack), 32'd0);
        chk("rd_idle_grant",32'(grant),  32'd0);
        chk("rd_hold",      32'(m0_rdata), 32'hBEEF);

        // Both ports requesting continuously from reset: alternate 01,10,01,10
        reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rr_acc_grant", 32'(grant),  (k % 2 == 0) ? 32'b01 : 32'b10);
            chk("rr_acc_en",    32'(mem_en), 32'd1);
            step();
            chk("rr_done_en",   32'(mem_en), 32'd0);
            chk("rr_done_ack",  32'({m1_ack, m0_ack}), (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k == 3) begin
                m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
            end
            step();
            chk("rr_gap_en",    32'(mem_en), 32'd0);
            chk("rr_gap_grant", 32'(grant),  32'd0);
            if (k < 3) step();
        end
        chk("rr_m1_rdata", 32'(m1_rdata), 32'h5A5A);

        // m1 write; fields changed after the grant must not reach the bus
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h0A5; m1_wdata = 16'h1234;
        step();
        chk("wr_grant", 32'(grant),     32'b10);
        chk("wr_we",    32'(mem_we),    32'd1);
        chk("wr_addr",  32'(mem_addr),  32'h0A5);
        chk("wr_wdata", 32'(mem_wdata), 32'h1234);
        m1_wdata = 16'hFFFF; m1_addr = 12'h3FF;
        step();
        chk("wr_wdata_held", 32'(mem_wdata), 32'h1234);
        chk("wr_addr_held",  32'(mem_addr),  32'h0A5);
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        step();
        chk("wr_ack",   32'(m1_ack),   32'd1);
        chk("wr_err",   32'(m1_err),   32'd0);
        chk("wr_rdata", 32'(m1_rdata), 32'h5A5A);
        m1_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("wr_ack_pulse", 32'(m1_ack),   32'd0);
        chk("wr_rdata_hold",32'(m1_rdata), 32'h5A5A);

        // m0 read that the memory never answers
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h456; mem_rdata = 16'h1111;
        en_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m0_ack) break;
            if (mem_en) en_cycles++;
        end
        chk("to_en_cycles", 32'(en_cycles), 32'd15);
        chk("to_ack",       32'(m0_ack),    32'd1);
        chk("to_err",       32'(m0_err),    32'd1);
        chk("to_mem_en",    32'(mem_en),    32'd0);
        chk("to_rdata",     32'(m0_rdata),  32'h5A5A);
        m0_req = 1'b0;
        step();
        chk("to_clear", 32'({m0_ack, m0_err}), 32'd0);

        // Reset during ACCESS, then a fresh read completes
        m0_req = 1'b1; m0_addr = 12'h321;
        step();
        chk("ra_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        step();
        chk("ra_mem_en_off", 32'(mem_en), 32'd0);
        chk("ra_busy",       32'(busy),   32'd0);
        chk("ra_grant",      32'(grant),  32'd0);
        chk("ra_noack",      32'(m0_ack), 32'd0);
        chk("ra_rdata",      32'(m0_rdata), 32'd0);
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hCAFE;
        step();
        chk("ra2_en",   32'(mem_en),   32'd1);
        chk("ra2_addr", 32'(mem_addr), 32'h321);
        step();
        chk("ra2_ack",   32'(m0_ack),   32'd1);
        chk("ra2_rdata", 32'(m0_rdata), 32'hCAFE);
        m0_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("ra2_idle", 32'({busy, m0_ack, mem_en}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
